// File: rtl/i2c_sensor_responder.sv
`default_nettype none
// ============================================================================
// i2c_sensor_responder : I2C slave front end exposing a 16-bit sensor register
// bank. Optional read-back path enabled by macro I2C_SENSOR_READ_EN.
// Revision: 1.0
// ============================================================================
module i2c_sensor_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h5D,
  parameter int         FILTER_LEN  = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic [15:0] exposure,
  output logic [15:0] start_row,
  output logic [15:0] start_column,
  output logic [15:0] row_size,
  output logic [15:0] column_size,
  output logic [15:0] row_mode,
  output logic [15:0] column_mode,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy
);
  localparam logic [3:0] S_IDLE    = 4'd0,  S_DEV     = 4'd1,  S_DEV_ACK = 4'd2,
                         S_SUB     = 4'd3,  S_SUB_ACK = 4'd4,  S_WHI     = 4'd5,
                         S_WHI_ACK = 4'd6,  S_WLO     = 4'd7,  S_WLO_ACK = 4'd8;
`ifdef I2C_SENSOR_READ_EN
  localparam logic [3:0] S_RHI     = 4'd9,  S_RHI_ACK = 4'd10, S_RLO     = 4'd11,
                         S_RLO_ACK = 4'd12;
`endif

  logic [1:0]            r_scl_sync, r_sda_sync;
  logic [FILTER_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                  r_scl, r_sda, r_scl_d, r_sda_d;

  // The bus pipeline is left unreset so asserting reset never fabricates a START/STOP.
  always_ff @(posedge clock) begin
    r_scl_sync    <= {r_scl_sync[0], I2C_SCLK};
    r_sda_sync    <= {r_sda_sync[0], I2C_SDAT};
    r_scl_hist[0] <= r_scl_sync[1];
    r_sda_hist[0] <= r_sda_sync[1];
    for (int i = 1; i < FILTER_LEN; i++) begin
      r_scl_hist[i] <= r_scl_hist[i-1];
      r_sda_hist[i] <= r_sda_hist[i-1];
    end
    if (&r_scl_hist) r_scl <= 1'b1;
    else if (~|r_scl_hist) r_scl <= 1'b0;
    if (&r_sda_hist) r_sda <= 1'b1;
    else if (~|r_sda_hist) r_sda <= 1'b0;
    r_scl_d <= r_scl;
    r_sda_d <= r_sda;
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_rx_state, w_dev_match;
  assign w_scl_rise = r_scl & ~r_scl_d;
  assign w_scl_fall = ~r_scl & r_scl_d;
  assign w_start    = r_scl & r_scl_d & r_sda_d & ~r_sda;
  assign w_stop     = r_scl & r_scl_d & ~r_sda_d & r_sda;

  logic [3:0]  r_state, r_cnt;
  logic [7:0]  r_shift, r_ptr, r_hi;
  logic        r_sda_low;
  logic [15:0] w_word;

  assign w_rx_state = (r_state == S_DEV) || (r_state == S_SUB) ||
                      (r_state == S_WHI) || (r_state == S_WLO);
  assign w_word     = {r_hi, r_shift};
  assign I2C_SDAT   = r_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_SENSOR_READ_EN
  logic        r_rw, r_mack;
  logic [7:0]  r_tx, w_rd_ptr;
  logic [15:0] w_rd_word;
  assign w_dev_match = (r_shift[7:1] == DEVICE_ADDR);
  // Looks one word ahead while acknowledging so a burst read can start driving immediately.
  assign w_rd_ptr    = (r_state == S_RLO_ACK) ? r_ptr + 8'd1 : r_ptr;
  always_comb begin
    w_rd_word = 16'h0000;
    case (w_rd_ptr)
      8'h01:   w_rd_word = start_row;
      8'h02:   w_rd_word = start_column;
      8'h03:   w_rd_word = row_size;
      8'h04:   w_rd_word = column_size;
      8'h09:   w_rd_word = exposure;
      8'h22:   w_rd_word = row_mode;
      8'h23:   w_rd_word = column_mode;
      default: w_rd_word = 16'h0000;
    endcase
  end
`else
  assign w_dev_match = (r_shift == {DEVICE_ADDR, 1'b0});
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_ptr        <= '0;
      r_hi         <= '0;
      r_sda_low    <= 1'b0;
      busy         <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      exposure     <= 16'h0797;
      start_row    <= 16'h0036;
      start_column <= 16'h0010;
      row_size     <= 16'h05FF;
      column_size  <= 16'h07FF;
      row_mode     <= 16'h0000;
      column_mode  <= 16'h0000;
`ifdef I2C_SENSOR_READ_EN
      r_rw         <= 1'b0;
      r_mack       <= 1'b0;
      r_tx         <= '0;
`endif
    end else begin
      wr_valid <= 1'b0;
      if (w_start || w_stop) begin
        busy      <= w_start;
        r_state   <= w_start ? S_DEV : S_IDLE;
        r_cnt     <= '0;
        r_sda_low <= 1'b0;
      end else if (w_scl_rise) begin
        if (w_rx_state) begin
          r_shift <= {r_shift[6:0], r_sda};
          r_cnt   <= r_cnt + 4'd1;
        end
`ifdef I2C_SENSOR_READ_EN
        if (r_state == S_RLO_ACK) r_mack <= ~r_sda;
`endif
      end else if (w_scl_fall) begin
        case (r_state)
          S_DEV: if (r_cnt == 4'd8) begin
            r_cnt     <= '0;
            r_state   <= w_dev_match ? S_DEV_ACK : S_IDLE;
            r_sda_low <= w_dev_match;
`ifdef I2C_SENSOR_READ_EN
            r_rw      <= r_shift[0];
`endif
          end
          S_SUB: if (r_cnt == 4'd8) begin
            r_cnt     <= '0;
            r_state   <= S_SUB_ACK;
            r_sda_low <= 1'b1;
            r_ptr     <= r_shift;
          end
          S_WHI: if (r_cnt == 4'd8) begin
            r_cnt     <= '0;
            r_state   <= S_WHI_ACK;
            r_sda_low <= 1'b1;
            r_hi      <= r_shift;
          end
          S_WLO: if (r_cnt == 4'd8) begin
            r_cnt     <= '0;
            r_state   <= S_WLO_ACK;
            r_sda_low <= 1'b1;
            wr_valid  <= 1'b1;
            wr_addr   <= r_ptr;
            wr_data   <= w_word;
            r_ptr     <= r_ptr + 8'd1;
            case (r_ptr)
              8'h01:   start_row    <= w_word;
              8'h02:   start_column <= w_word;
              8'h03:   row_size     <= w_word;
              8'h04:   column_size  <= w_word;
              8'h09:   exposure     <= w_word;
              8'h22:   row_mode     <= w_word;
              8'h23:   column_mode  <= w_word;
              default: ;
            endcase
          end
          S_DEV_ACK: begin
            r_sda_low <= 1'b0;
            r_state   <= S_SUB;
`ifdef I2C_SENSOR_READ_EN
            if (r_rw) begin
              r_state   <= S_RHI;
              r_sda_low <= ~w_rd_word[15];
              r_tx      <= {w_rd_word[14:8], 1'b0};
              r_cnt     <= 4'd1;
            end
`endif
          end
          S_SUB_ACK, S_WLO_ACK: begin
            r_sda_low <= 1'b0;
            r_state   <= S_WHI;
          end
          S_WHI_ACK: begin
            r_sda_low <= 1'b0;
            r_state   <= S_WLO;
          end
`ifdef I2C_SENSOR_READ_EN
          S_RHI, S_RLO: begin
            if (r_cnt != 4'd8) begin
              r_sda_low <= ~r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b0};
              r_cnt     <= r_cnt + 4'd1;
            end else begin
              r_sda_low <= 1'b0;
              r_cnt     <= '0;
              r_state   <= (r_state == S_RHI) ? S_RHI_ACK : S_RLO_ACK;
            end
          end
          S_RHI_ACK: begin
            r_state   <= S_RLO;
            r_sda_low <= ~w_rd_word[7];
            r_tx      <= {w_rd_word[6:0], 1'b0};
            r_cnt     <= 4'd1;
          end
          S_RLO_ACK: begin
            if (r_mack) begin
              r_ptr     <= r_ptr + 8'd1;
              r_state   <= S_RHI;
              r_sda_low <= ~w_rd_word[15];
              r_tx      <= {w_rd_word[14:8], 1'b0};
              r_cnt     <= 4'd1;
            end else begin
              r_state   <= S_IDLE;
              r_sda_low <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/i2c_sensor_responder.md
I2C_SENSOR_RESPONDER -- requirements
Module: i2c_sensor_responder

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h5D, 7-bit I2C slave address (write byte 0xBA, read byte 0xBB).
REQ-002 Parameter FILTER_LEN, default 3, number of consecutive equal samples required before a synchronized SCL/SDA level is accepted.
REQ-003 clock  input  1  system clock; all logic SHALL be in this single clock domain.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 I2C_SCLK  input  1  I2C clock from the bus master; asynchronous to clock.
REQ-006 I2C_SDAT  inout  1  I2C data, open-drain: driven 0 or high-Z, never driven 1.
REQ-007 exposure, start_row, start_column, row_size, column_size, row_mode, column_mode  output  16 each  current contents of sensor registers 0x09, 0x01, 0x02, 0x03, 0x04, 0x22, 0x23.
REQ-008 wr_valid  output  1  one-clock pulse per committed register write.
REQ-009 wr_addr  output  8  sub-address of the committed write; valid with wr_valid.
REQ-010 wr_data  output  16  data of the committed write; valid with wr_valid.
REQ-011 busy  output  1  high from START detection until STOP detection.

Function
REQ-012 The block SHALL pass SCL and SDA through a 2-flop synchronizer followed by the FILTER_LEN glitch filter, and SHALL derive all edges from the filtered signals.
REQ-013 START (also repeated START) SHALL be SDA falling while SCL high; STOP SHALL be SDA rising while SCL high; either event SHALL abort any transfer in progress from any state.
REQ-014 Received bits SHALL be sampled on SCL rising edges, MSB first; SDA SHALL be changed only on SCL falling edges.
REQ-015 FSM states: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WHI, WHI_ACK, WLO, WLO_ACK, RHI, RHI_ACK, RLO, RLO_ACK.
REQ-016 IDLE -> DEV on START; DEV shifts 8 bits; address match -> DEV_ACK (drive 0 for one SCL period), mismatch -> IDLE with SDA released until next START.
REQ-017 After a write-direction DEV_ACK: SUB (8 bits, pointer <= byte) -> SUB_ACK -> WHI (MSB byte) -> WHI_ACK -> WLO (LSB byte) -> WLO_ACK -> WHI.
REQ-018 At WLO_ACK the 16-bit word SHALL be committed to the register at the pointer: wr_valid pulses once with wr_addr/wr_data, and the matching register output updates on the same cycle.
REQ-019 After each commit the pointer SHALL increment by 1, wrapping 0xFF -> 0x00.
REQ-020 Writes to unimplemented sub-addresses SHALL be ACKed and SHALL pulse wr_valid without changing any register output.
REQ-021 A STOP or START received before WLO_ACK SHALL discard the partial word; no wr_valid pulse.
REQ-022 Every byte addressed to DEVICE_ADDR SHALL be ACKed; no NACK on write data.

Reset
REQ-023 On reset_n low at a clock edge: FSM -> IDLE, SDA released, busy=0, wr_valid=0, wr_addr=0, wr_data=0, pointer=0.
REQ-024 Reset register values: exposure 0x0797, start_row 0x0036, start_column 0x0010, row_size 0x05FF, column_size 0x07FF, row_mode 0x0000, column_mode 0x0000.
REQ-025 Reset asserted mid-transfer SHALL release SDA on the next clock edge, and the block SHALL ignore the bus until the next START after reset deasserts.

Configuration
REQ-026 With macro I2C_SENSOR_READ_EN defined: a read-direction DEV_ACK -> RHI (transmit register[pointer][15:8]) -> RHI_ACK -> RLO (transmit [7:0]) -> RLO_ACK; master ACK at RLO_ACK -> pointer+1 and RHI; master NACK -> released until STOP/START; unimplemented addresses read 0x0000.
REQ-027 Without I2C_SENSOR_READ_EN: read-direction address bytes SHALL be NACKed and treated as a mismatch; no read logic SHALL be synthesized.

Verification
REQ-028 Write 0xBA, 0x09, 0x01, 0x23, STOP -> exposure=0x0123; one wr_valid with wr_addr=0x09, wr_data=0x0123; all ACKs low.
REQ-029 Address byte 0xC0 -> SDA never driven low; registers unchanged; busy falls at STOP.
REQ-030 Burst 0xBA, 0x01, 0x0040, 0x0020, STOP -> start_row=0x0040, start_column=0x0020, two wr_valid pulses.
REQ-031 Write 0xBA, 0x03, 0x04, STOP after MSB -> row_size stays 0x05FF; no wr_valid.
REQ-032 READ_EN: 0xBA, 0x02, rSTART, 0xBB -> returns 0x0010, master NACK, STOP; without macro, 0xBB is NACKed.
REQ-033 Reset pulse mid-WHI -> SDA released within 1 clock; registers at reset values; the next full write succeeds.
